// File: rtl/perceptron_pkg.sv
// Shared types and default feature widths for the digit perceptron datapath.
package perceptron_pkg;

    localparam int unsigned EDGE_W_DEF  = 3;
    localparam int unsigned CURVE_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        HOLD
    } state_t;

endpackage

// File: rtl/stroke_feature_accumulator_sat_counter.sv
// Saturating up-counter with synchronous clear; sat_hit flags an increment
// request that arrives while the counter is already at its maximum.
module sat_counter #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         sat_hit
);

    assign sat_hit = inc && (cnt == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !sat_hit) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/stroke_feature_accumulator.sv
// Counts edge/curve strokes per glyph frame and hands the saturated pair
// downstream over valid/ready. Define STROKE_OVF_EN to add the ovf output.
module stroke_feature_accumulator
    import perceptron_pkg::*;
#(
    parameter int unsigned EDGE_W  = EDGE_W_DEF,
    parameter int unsigned CURVE_W = CURVE_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_start,
    input  logic               frame_end,
    input  logic               stroke_valid,
    input  logic               stroke_is_curve,
    output logic               frame_ready,
    output logic               feat_valid,
    input  logic               feat_ready,
    output logic [EDGE_W-1:0]  edges,
    output logic [CURVE_W-1:0] curves
`ifdef STROKE_OVF_EN
    ,
    output logic               ovf
`endif
);

    state_t state, state_next;

    logic               cnt_clr;
    logic               stroke_ok;
    logic               inc_edge, inc_curve;
    logic               edge_sat_hit, curve_sat_hit;
    logic [EDGE_W-1:0]  edge_cnt, edge_fin, load_edges;
    logic [CURVE_W-1:0] curve_cnt, curve_fin, load_curves;
    logic               out_free;
    logic               load;
`ifdef STROKE_OVF_EN
    logic               ovf_flag;
    logic               load_ovf;
`endif

    // A restart cycle (frame_start without frame_end) discards its stroke.
    assign stroke_ok = (state == COLLECT) && stroke_valid && !(frame_start && !frame_end);
    assign inc_edge  = stroke_ok && !stroke_is_curve;
    assign inc_curve = stroke_ok && stroke_is_curve;

    // Final counts including a stroke arriving in the frame_end cycle.
    assign edge_fin  = (inc_edge && !edge_sat_hit)   ? edge_cnt + EDGE_W'(1)   : edge_cnt;
    assign curve_fin = (inc_curve && !curve_sat_hit) ? curve_cnt + CURVE_W'(1) : curve_cnt;

    assign out_free    = !feat_valid || feat_ready;
    assign frame_ready = (state != HOLD);

    sat_counter #(.W(EDGE_W)) u_edge_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (cnt_clr),
        .inc     (inc_edge),
        .cnt     (edge_cnt),
        .sat_hit (edge_sat_hit)
    );

    sat_counter #(.W(CURVE_W)) u_curve_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (cnt_clr),
        .inc     (inc_curve),
        .cnt     (curve_cnt),
        .sat_hit (curve_sat_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        cnt_clr     = 1'b0;
        load        = 1'b0;
        load_edges  = edge_cnt;
        load_curves = curve_cnt;
`ifdef STROKE_OVF_EN
        load_ovf    = ovf_flag;
`endif
        unique case (state)
            IDLE: begin
                if (frame_start) begin
                    cnt_clr = 1'b1;
                    if (frame_end) begin
                        load_edges  = '0;
                        load_curves = '0;
`ifdef STROKE_OVF_EN
                        load_ovf    = 1'b0;
`endif
                        load       = out_free;
                        state_next = out_free ? IDLE : HOLD;
                    end else begin
                        state_next = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (frame_end) begin
                    load_edges  = edge_fin;
                    load_curves = curve_fin;
`ifdef STROKE_OVF_EN
                    load_ovf    = ovf_flag || edge_sat_hit || curve_sat_hit;
`endif
                    load       = out_free;
                    state_next = out_free ? IDLE : HOLD;
                end else if (frame_start) begin
                    cnt_clr = 1'b1;
                end
            end
            HOLD: begin
                if (out_free) begin
                    load       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            feat_valid <= 1'b0;
            edges      <= '0;
            curves     <= '0;
        end else if (load) begin
            feat_valid <= 1'b1;
            edges      <= load_edges;
            curves     <= load_curves;
        end else if (feat_valid && feat_ready) begin
            feat_valid <= 1'b0;
        end
    end

`ifdef STROKE_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_flag <= 1'b0;
        end else if (cnt_clr) begin
            ovf_flag <= 1'b0;
        end else if (edge_sat_hit || curve_sat_hit) begin
            ovf_flag <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (load) begin
            ovf <= load_ovf;
        end
    end
`endif

endmodule

// File: tb/tb_stroke_feature_accumulator.sv
// Directed bench for stroke_feature_accumulator: per-cycle compare against a
// frame-level behavioural model plus hand-computed checkpoints.
module tb_stroke_feature_accumulator;

    localparam int EMAX = 7;
    localparam int CMAX = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_start = 1'b0;
    logic       frame_end = 1'b0;
    logic       stroke_valid = 1'b0;
    logic       stroke_is_curve = 1'b0;
    logic       feat_ready = 1'b1;
    logic       frame_ready;
    logic       feat_valid;
    logic [2:0] edges;
    logic [3:0] curves;

    int n_vec = 0;
    int n_err = 0;

    stroke_feature_accumulator #(.EDGE_W(3), .CURVE_W(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .frame_start     (frame_start),
        .frame_end       (frame_end),
        .stroke_valid    (stroke_valid),
        .stroke_is_curve (stroke_is_curve),
        .frame_ready     (frame_ready),
        .feat_valid      (feat_valid),
        .feat_ready      (feat_ready),
        .edges           (edges),
        .curves          (curves)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Frame-level model: unbounded stroke tallies, clipped only at delivery.
    bit m_in_frame, m_pend, m_out_v, m_free, m_close, m_deliver;
    int m_acc_e, m_acc_c, m_pend_e, m_pend_c, m_out_e, m_out_c, m_de, m_dc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_in_frame = 0; m_pend = 0; m_out_v = 0;
            m_acc_e = 0; m_acc_c = 0; m_pend_e = 0; m_pend_c = 0;
            m_out_e = 0; m_out_c = 0;
        end else begin
            m_free = !m_out_v || feat_ready;
            m_close = 0;
            m_deliver = 0;
            m_de = 0;
            m_dc = 0;
            if (m_pend) begin
                if (m_free) begin
                    m_deliver = 1; m_de = m_pend_e; m_dc = m_pend_c; m_pend = 0;
                end
            end else if (!m_in_frame) begin
                if (frame_start) begin
                    m_acc_e = 0; m_acc_c = 0;
                    if (frame_end) m_close = 1;
                    else m_in_frame = 1;
                end
            end else begin
                if (stroke_valid && !(frame_start && !frame_end)) begin
                    if (stroke_is_curve) m_acc_c++;
                    else m_acc_e++;
                end
                if (frame_end) begin
                    m_close = 1; m_in_frame = 0;
                end else if (frame_start) begin
                    m_acc_e = 0; m_acc_c = 0;
                end
            end
            if (m_close) begin
                m_de = (m_acc_e > EMAX) ? EMAX : m_acc_e;
                m_dc = (m_acc_c > CMAX) ? CMAX : m_acc_c;
                if (m_free) m_deliver = 1;
                else begin
                    m_pend = 1; m_pend_e = m_de; m_pend_c = m_dc;
                end
            end
            if (m_deliver) begin
                m_out_v = 1; m_out_e = m_de; m_out_c = m_dc;
            end else if (m_out_v && feat_ready) begin
                m_out_v = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_feat_valid", int'(feat_valid), int'(m_out_v));
        chk("cyc_edges", int'(edges), m_out_e);
        chk("cyc_curves", int'(curves), m_out_c);
        chk("cyc_frame_ready", int'(frame_ready), int'(!m_pend));
    end

    task automatic drive(input bit fs, input bit fe, input bit sv, input bit cv);
        frame_start = fs; frame_end = fe; stroke_valid = sv; stroke_is_curve = cv;
        @(posedge clk);
        #1;
        frame_start = 0; frame_end = 0; stroke_valid = 0; stroke_is_curve = 0;
    endtask

    task automatic strokes(input int n, input bit cv);
        for (int i = 0; i < n; i++) drive(0, 0, 1, cv);
    endtask

    task automatic async_reset(input string nm);
        #1 rst_n = 0;
        #1;
        chk({nm, "_valid"}, int'(feat_valid), 0);
        chk({nm, "_edges"}, int'(edges), 0);
        chk({nm, "_curves"}, int'(curves), 0);
        chk({nm, "_frame_ready"}, int'(frame_ready), 1);
        @(negedge clk);
        #1 rst_n = 1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_valid", int'(feat_valid), 0);
        chk("rst_edges", int'(edges), 0);
        chk("rst_curves", int'(curves), 0);
        chk("rst_frame_ready", int'(frame_ready), 1);
        #1 rst_n = 1;

        // basic frame: 2 edges, 4 curves
        drive(1, 0, 0, 0); strokes(2, 0); strokes(4, 1); drive(0, 1, 0, 0);
        chk("basic_valid", int'(feat_valid), 1);
        chk("basic_edges", int'(edges), 2);
        chk("basic_curves", int'(curves), 4);
        drive(0, 0, 0, 0);
        chk("basic_ack_drop", int'(feat_valid), 0);

        // saturation
        drive(1, 0, 0, 0); strokes(9, 0); strokes(17, 1); drive(0, 1, 0, 0);
        chk("sat_edges", int'(edges), 7);
        chk("sat_curves", int'(curves), 15);

        // stroke in the frame_end cycle counts
        drive(1, 0, 0, 0); strokes(2, 0); drive(0, 1, 1, 0);
        chk("fe_stroke_edges", int'(edges), 3);
        chk("fe_stroke_curves", int'(curves), 0);

        // frame_start+frame_end in COLLECT closes, no restart
        drive(1, 0, 0, 0); strokes(1, 0); drive(1, 1, 0, 0);
        chk("fsfe_collect_valid", int'(feat_valid), 1);
        chk("fsfe_collect_edges", int'(edges), 1);
        drive(0, 0, 1, 0); drive(0, 1, 0, 0);
        chk("idle_fe_ignored", int'(feat_valid), 0);

        // zero-length frame from IDLE
        drive(1, 1, 0, 0);
        chk("zero_valid", int'(feat_valid), 1);
        chk("zero_edges", int'(edges), 0);
        chk("zero_curves", int'(curves), 0);

        // restart discards earlier strokes and the restart-cycle stroke
        drive(1, 0, 0, 0); strokes(5, 1); drive(1, 0, 1, 1); strokes(1, 1); drive(0, 1, 0, 0);
        chk("restart_edges", int'(edges), 0);
        chk("restart_curves", int'(curves), 1);
        drive(0, 0, 0, 0);

        // backpressure: A=1/3 delivered, B=4/2 held
        feat_ready = 0;
        drive(1, 0, 0, 0); strokes(1, 0); strokes(3, 1); drive(0, 1, 0, 0);
        chk("bp_a_valid", int'(feat_valid), 1);
        chk("bp_a_edges", int'(edges), 1);
        chk("bp_a_curves", int'(curves), 3);
        drive(1, 0, 0, 0); strokes(4, 0); strokes(2, 1); drive(0, 1, 0, 0);
        chk("bp_hold_frame_ready", int'(frame_ready), 0);
        chk("bp_hold_edges", int'(edges), 1);
        chk("bp_hold_curves", int'(curves), 3);
        drive(1, 1, 1, 0);
        chk("bp_hold_ignore_ready", int'(frame_ready), 0);
        chk("bp_hold_ignore_edges", int'(edges), 1);
        feat_ready = 1;
        drive(0, 0, 0, 0);
        chk("bp_b_valid", int'(feat_valid), 1);
        chk("bp_b_edges", int'(edges), 4);
        chk("bp_b_curves", int'(curves), 2);
        chk("bp_b_frame_ready", int'(frame_ready), 1);

        // reset while collecting
        drive(1, 0, 0, 0); strokes(3, 0);
        async_reset("rst_collect");
        drive(0, 1, 0, 0);
        chk("rst_collect_idle", int'(feat_valid), 0);

        // reset while holding
        feat_ready = 0;
        drive(1, 0, 0, 0); strokes(1, 0); drive(0, 1, 0, 0);
        chk("rst_hold_pre_edges", int'(edges), 1);
        drive(1, 0, 0, 0); strokes(2, 1); drive(0, 1, 0, 0);
        chk("rst_hold_pre_ready", int'(frame_ready), 0);
        async_reset("rst_hold");
        feat_ready = 1;
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("rst_hold_idle", int'(feat_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
